// File: rtl/multicycle_control_unit.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB with memory handshake,
// stall, illegal-opcode and memory-timeout traps, and a retired-instruction counter.
module multicycle_control_unit #(
  parameter int OPCODE_WIDTH = 3,
  parameter int MEM_TIMEOUT  = 0,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [OPCODE_WIDTH-1:0] opcode,
  input  logic                    zero,
  input  logic                    mem_ready,
  input  logic                    stall,
  output logic                    pc_write,
  output logic [1:0]              pc_src,
  output logic                    ir_write,
  output logic                    i_or_d,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic [1:0]              reg_dst,
  output logic [1:0]              mem_to_reg,
  output logic                    reg_write,
  output logic                    alu_src,
  output logic [1:0]              alu_op,
  output logic                    sign_or_zero,
  output logic                    instr_done,
  output logic                    illegal_op,
  output logic                    timeout_err,
  output logic [2:0]              state,
  output logic [CNT_WIDTH-1:0]    instr_count
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SLI  = 3'd1;
  localparam logic [2:0] OP_J    = 3'd2;
  localparam logic [2:0] OP_JAL  = 3'd3;
  localparam logic [2:0] OP_LW   = 3'd4;
  localparam logic [2:0] OP_SW   = 3'd5;
  localparam logic [2:0] OP_BEQ  = 3'd6;
  localparam logic [2:0] OP_ADDI = 3'd7;

  localparam bit TIMEOUT_EN = (MEM_TIMEOUT > 0);
  localparam int WAIT_W     = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

  state_t                 state_q, state_d;
  logic [2:0]             op_q;
  logic [WAIT_W-1:0]      wait_q;
  logic                   illegal_q, timeout_q;
  logic                   set_illegal, set_timeout;
  logic [CNT_WIDTH-1:0]   cnt_q;
  logic                   legal;
  logic                   timeout_hit;

  // Only the low three opcode bits carry meaning; anything above must be zero.
  assign legal       = ((opcode >> 3) == '0);
  assign timeout_hit = TIMEOUT_EN && !mem_ready && (wait_q == WAIT_W'(MEM_TIMEOUT - 1));

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    state_d      = state_q;
    set_illegal  = 1'b0;
    set_timeout  = 1'b0;
    pc_write     = 1'b0;
    pc_src       = 2'b00;
    ir_write     = 1'b0;
    i_or_d       = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    reg_dst      = 2'b00;
    mem_to_reg   = 2'b00;
    reg_write    = 1'b0;
    alu_src      = 1'b0;
    alu_op       = 2'b00;
    sign_or_zero = 1'b1;
    instr_done   = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end else if (timeout_hit) begin
          state_d     = S_TRAP;
          set_timeout = 1'b1;
        end
      end
      S_DECODE: begin
        if (!legal) begin
          state_d     = S_TRAP;
          set_illegal = 1'b1;
        end else if (opcode[2:0] == OP_J || opcode[2:0] == OP_JAL) begin
          pc_write   = 1'b1;
          pc_src     = 2'b10;
          instr_done = 1'b1;
          state_d    = S_FETCH;
          if (opcode[2:0] == OP_JAL) begin
            reg_write  = 1'b1;
            reg_dst    = 2'b10;
            mem_to_reg = 2'b10;
          end
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        case (op_q)
          OP_ADD:  state_d = S_WB;
          OP_SLI: begin
            alu_op       = 2'b10;
            alu_src      = 1'b1;
            sign_or_zero = 1'b0;
            state_d      = S_WB;
          end
          OP_ADDI: begin
            alu_op  = 2'b11;
            alu_src = 1'b1;
            state_d = S_WB;
          end
          OP_LW, OP_SW: begin
            alu_op  = 2'b11;
            alu_src = 1'b1;
            state_d = S_MEM;
          end
          OP_BEQ: begin
            alu_op     = 2'b01;
            pc_src     = 2'b01;
            pc_write   = zero;
            instr_done = 1'b1;
            state_d    = S_FETCH;
          end
          default: state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        i_or_d    = 1'b1;
        mem_read  = (op_q == OP_LW);
        mem_write = (op_q == OP_SW);
        if (mem_ready) begin
          instr_done = (op_q == OP_SW);
          state_d    = (op_q == OP_SW) ? S_FETCH : S_WB;
        end else if (timeout_hit) begin
          state_d     = S_TRAP;
          set_timeout = 1'b1;
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        reg_dst    = (op_q == OP_ADD) ? 2'b01 : 2'b00;
        mem_to_reg = (op_q == OP_LW)  ? 2'b01 : 2'b00;
        state_d    = S_FETCH;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase

    // A stall freezes sequencing and swallows any coincident mem_ready.
    if (stall) begin
      state_d     = state_q;
      set_illegal = 1'b0;
      set_timeout = 1'b0;
      pc_write    = 1'b0;
      ir_write    = 1'b0;
      reg_write   = 1'b0;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      instr_done  = 1'b0;
    end

    if (!reset) begin
      pc_write     = 1'b0;
      pc_src       = 2'b00;
      ir_write     = 1'b0;
      i_or_d       = 1'b0;
      mem_read     = 1'b0;
      mem_write    = 1'b0;
      reg_dst      = 2'b00;
      mem_to_reg   = 2'b00;
      reg_write    = 1'b0;
      alu_src      = 1'b0;
      alu_op       = 2'b00;
      sign_or_zero = 1'b1;
      instr_done   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      op_q      <= '0;
      wait_q    <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      if (!stall && state_q == S_DECODE) op_q <= opcode[2:0];
      if (state_d != state_q) begin
        wait_q <= '0;
      end else if (TIMEOUT_EN && !stall && !mem_ready &&
                   (state_q == S_FETCH || state_q == S_MEM)) begin
        wait_q <= wait_q + WAIT_W'(1);
      end
      if (set_illegal) illegal_q <= 1'b1;
      if (set_timeout) timeout_q <= 1'b1;
      if (instr_done)  cnt_q     <= cnt_q + CNT_WIDTH'(1);
    end
  end

  assign state       = state_q;
  assign illegal_op  = illegal_q;
  assign timeout_err = timeout_q;
  assign instr_count = cnt_q;

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Multi-cycle successor to the single-cycle opcode decoder; sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states.
- Drives datapath enables and muxes for the shared-memory, shared-ALU processor core.
- Supports variable-latency memory through a `mem_ready` handshake, a pipeline-style `stall`, illegal-opcode trapping, an optional memory timeout and a retired-instruction counter.
- Sits between the instruction register and the datapath, replacing the per-cycle decode.

Parameters:
- OPCODE_WIDTH, 3, opcode width (>=3); only encodings with upper bits [OPCODE_WIDTH-1:3] all zero are legal.
- MEM_TIMEOUT, 0, max wait cycles for `mem_ready` in FETCH/MEM; 0 disables the timeout.
- CNT_WIDTH, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- opcode  in  OPCODE_WIDTH  opcode field from the instruction register
- zero  in  1  ALU zero flag (beq)
- mem_ready  in  1  memory access complete this cycle
- stall  in  1  freeze sequencing
- pc_write  out  1  PC load enable
- pc_src  out  2  00 PC+1, 01 branch target, 10 jump target
- ir_write  out  1  instruction register load
- i_or_d  out  1  memory address select: 0 PC, 1 ALU result
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- reg_dst  out  2  00 rt, 01 rd, 10 link register
- mem_to_reg  out  2  00 ALU, 01 memory, 10 PC+1
- reg_write  out  1  register file write enable
- alu_src  out  1  0 register, 1 immediate
- alu_op  out  2  ALU function class
- sign_or_zero  out  1  1 sign-extend, 0 zero-extend
- instr_done  out  1  one-cycle pulse when an instruction retires
- illegal_op  out  1  sticky trap flag, illegal opcode
- timeout_err  out  1  sticky trap flag, memory timeout
- state  out  3  current state: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5
- instr_count  out  CNT_WIDTH  retired instructions, wraps to 0

Behaviour:
- Reset low (async):
  - state=FETCH, op_q=0, wait counter=0, instr_count=0, flags=0.
  - While reset is low, all outputs are 0 except sign_or_zero=1.
  - Reset mid-instruction aborts the instruction with no write enables asserted.
- Outputs are combinational from state and op_q. In DECODE they are taken from `opcode` directly.
- Unlisted outputs are 0; sign_or_zero=1 except for sli.
- Opcode map: add=000, sli=001, j=010, jal=011, lw=100, sw=101, beq=110, addi=111.
- FETCH:
  - Drive mem_read=1, i_or_d=0.
  - On mem_ready: ir_write=1, pc_write=1, pc_src=00, then go to DECODE. Otherwise stay.
- DECODE:
  - Register op_q<=opcode.
  - Illegal opcode: go to TRAP, illegal_op<=1.
  - j: pc_write=1, pc_src=10, instr_done=1, go to FETCH.
  - jal: j signals plus reg_write=1, reg_dst=10, mem_to_reg=10, then go to FETCH.
  - All other opcodes: go to EXEC.
- EXEC, per op_q:
  - add: alu_op=00, alu_src=0, go to WB.
  - sli: alu_op=10, alu_src=1, sign_or_zero=0, go to WB.
  - addi: alu_op=11, alu_src=1, go to WB.
  - lw/sw: alu_op=11, alu_src=1, go to MEM.
  - beq: alu_op=01, pc_src=01, pc_write=zero, instr_done=1, go to FETCH.
- MEM:
  - Drive i_or_d=1; lw drives mem_read=1, sw drives mem_write=1.
  - Hold until mem_ready. On mem_ready, sw retires (instr_done) and goes to FETCH; lw goes to WB.
- WB:
  - reg_write=1; then go to FETCH with instr_done=1.
  - add: reg_dst=01, mem_to_reg=00.
  - sli/addi: reg_dst=00, mem_to_reg=00.
  - lw: reg_dst=00, mem_to_reg=01.
- TRAP:
  - All enables and requests 0; the flags stay set.
  - TRAP is left only by reset.
- Latency with mem_ready=1 immediately:
  - j/jal: 2 cycles.
  - beq: 3 cycles.
  - add/sli/addi/sw: 4 cycles.
  - lw: 5 cycles.
- stall=1:
  - State, op_q, wait counter and instr_count all hold.
  - pc_write, ir_write, reg_write, mem_read, mem_write and instr_done are forced to 0.
  - stall overrides a coincident mem_ready; the ready is ignored and must be re-presented.
- Timeout (MEM_TIMEOUT>0):
  - The wait counter increments each non-stalled FETCH/MEM cycle without mem_ready and clears on state change.
  - When the count reaches MEM_TIMEOUT without mem_ready: go to TRAP, timeout_err<=1.
  - mem_ready on the same cycle wins over the timeout.
- instr_count increments on every instr_done and wraps from 2^CNT_WIDTH-1 to 0.

Test Plan:
- add with mem_ready held 1 → states 0,1,2,4,0; reg_write=1 with reg_dst=01 in cycle 4; instr_count=1.
- lw with mem_ready low for 3 MEM cycles → MEM held 4 cycles, mem_read=1, i_or_d=1 throughout; WB has mem_to_reg=01; total 8 cycles.
- beq, zero=1 then zero=0 → EXEC shows pc_write=1 with pc_src=01 in the first case, pc_write=0 in the second; both retire in 3 cycles.
- jal → DECODE shows pc_write=1, pc_src=10, reg_dst=10, mem_to_reg=10, reg_write=1; returns to FETCH.
- OPCODE_WIDTH=4, opcode=1000 → TRAP, illegal_op=1, all enables 0 for 10 cycles; reset low then high → FETCH, flags cleared.
- MEM_TIMEOUT=4, mem_ready=0 in FETCH → TRAP after 4 cycles, timeout_err=1. Separately: stall=1 for 3 cycles in WB → reg_write=0 and state held, then reg_write=1 once released.
